// File: rtl/seg595_rx.sv
// seg595_rx: receives 16-bit frames from a 74HC595-style serial bus
// (shift clock, latch clock, data). Each frame is one segment byte followed
// by one digit-select byte. A well-formed frame updates one of eight digit
// registers, and the module decodes the lit-segment pattern into a
// character code.
module seg595_rx #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk_in,
    input  logic        rclk_in,
    input  logic        sdio_in,
    output logic [63:0] seg_pat,
    output logic [39:0] seg_code,
    output logic [7:0]  dot_en,
    output logic        frame_valid,
    output logic [2:0]  frame_dig,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Character decode of the 7 segment bits {g,f,e,d,c,b,a}.
    // 16 = blank, 31 = unrecognised.
    function automatic logic [4:0] decode7(input logic [6:0] p);
        logic [4:0] c;
        case (p)
            7'h3F:   c = 5'd0;
            7'h06:   c = 5'd1;
            7'h5B:   c = 5'd2;
            7'h4F:   c = 5'd3;
            7'h66:   c = 5'd4;
            7'h6D:   c = 5'd5;
            7'h7D:   c = 5'd6;
            7'h07:   c = 5'd7;
            7'h7F:   c = 5'd8;
            7'h6F:   c = 5'd9;
            7'h77:   c = 5'd10;
            7'h7C:   c = 5'd11;
            7'h39:   c = 5'd12;
            7'h5E:   c = 5'd13;
            7'h79:   c = 5'd14;
            7'h71:   c = 5'd15;
            7'h00:   c = 5'd16;
            default: c = 5'd31;
        endcase
        return c;
    endfunction

    // Synchronizer and edge-detect bit order: {sdio, rclk, sclk}
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [1:0]  clk_prev;
    logic        sclk_rise;
    logic        rclk_rise;
    logic        sdio_s;

    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    state_t      state_reg;

    logic [15:0] shift_post;
    logic [4:0]  cnt_post;
    state_t      state_post;
    state_t      state_next;
    logic [4:0]  cnt_next;

    logic [7:0]  seg_corr;
    logic [7:0]  dig_corr;
    logic        dig_onehot;
    logic [2:0]  dig_idx;
    logic [4:0]  code_new;
    logic        accept;
    logic        reject;

    logic [7:0]  pat_reg  [8];
    logic [4:0]  code_reg [8];

    // Two-flop synchronizers plus a registered copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            clk_prev <= '0;
        end else begin
            sync1    <= {sdio_in, rclk_in, sclk_in};
            sync2    <= sync1;
            clk_prev <= sync2[1:0];
        end
    end

    assign sclk_rise = sync2[0] & ~clk_prev[0];
    assign rclk_rise = sync2[1] & ~clk_prev[1];
    assign sdio_s    = sync2[2];

    // Shift path: a shift in this cycle is applied before any latch looks at it
    always_comb begin
        shift_post = shift_reg;
        cnt_post   = bit_cnt;
        if (sclk_rise) begin
            shift_post = {shift_reg[14:0], sdio_s};
            if (bit_cnt != 5'd31) begin
                cnt_post = bit_cnt + 5'd1;
            end
        end
    end

    // FSM state register together with the bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            bit_cnt   <= cnt_next;
            shift_reg <= shift_post;
        end
    end

    // FSM next state: advance on a shift, then return to IDLE on any latch
    always_comb begin
        state_post = state_reg;
        if (sclk_rise) begin
            case (state_reg)
                ST_IDLE:  state_post = ST_SHIFT;
                ST_SHIFT: state_post = (cnt_post == 5'd16) ? ST_FULL : ST_SHIFT;
                ST_FULL:  state_post = ST_OVER;
                default:  state_post = ST_OVER;
            endcase
        end
        state_next = rclk_rise ? ST_IDLE : state_post;
        cnt_next   = rclk_rise ? 5'd0 : cnt_post;
    end

    // FSM outputs: judge the latched frame from the post-shift state and data
    always_comb begin
        seg_corr   = SEG_ACTIVE_LOW ? ~shift_post[15:8] : shift_post[15:8];
        dig_corr   = DIG_ACTIVE_LOW ? ~shift_post[7:0]  : shift_post[7:0];
        dig_onehot = (dig_corr != 8'd0) && ((dig_corr & (dig_corr - 8'd1)) == 8'd0);
        dig_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (dig_corr[i]) begin
                dig_idx = 3'(i);
            end
        end
        code_new = decode7(seg_corr[6:0]);
        accept   = rclk_rise && (state_post == ST_FULL) && dig_onehot;
        reject   = rclk_rise && !accept;
    end

    // Frame status pulses and last-updated digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_dig   <= 3'd0;
        end else begin
            frame_valid <= accept;
            frame_err   <= reject;
            if (accept) begin
                frame_dig <= dig_idx;
            end
        end
    end

    // One register pair per digit; untouched digits hold their value
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        // Load this digit only when an accepted frame addresses it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pat_reg[gi]  <= 8'd0;
                code_reg[gi] <= 5'd16;
            end else if (accept && (dig_idx == 3'(gi))) begin
                pat_reg[gi]  <= seg_corr;
                code_reg[gi] <= code_new;
            end
        end

        assign seg_pat[8*gi +: 8]  = pat_reg[gi];
        assign seg_code[5*gi +: 5] = code_reg[gi];
        assign dot_en[gi]          = pat_reg[gi][7];
    end

endmodule

// File: tb/tb_seg595_rx.sv
// tb_seg595_rx: directed frames over the serial bus. Expected frame
// events go into a scoreboard queue when a latch is driven, and a monitor
// pops and checks them as the pulses appear.
module tb_seg595_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk_in = 1'b0;
    logic        rclk_in = 1'b0;
    logic        sdio_in = 1'b0;
    logic [63:0] seg_pat;
    logic [39:0] seg_code;
    logic [7:0]  dot_en;
    logic        frame_valid;
    logic [2:0]  frame_dig;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        bit       is_valid;
        logic [2:0] dig;
        int       cyc;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_pat  [8];
    logic [4:0] m_code [8];
    logic [2:0] m_dig;

    seg595_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_in     (sclk_in),
        .rclk_in     (rclk_in),
        .sdio_in     (sdio_in),
        .seg_pat     (seg_pat),
        .seg_code    (seg_code),
        .dot_en      (dot_en),
        .frame_valid (frame_valid),
        .frame_dig   (frame_dig),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: every status pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_err)) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_pulse: valid=%0b err=%0b, expected no pulse", frame_valid, frame_err);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                assert (frame_valid === e.is_valid) else begin
                    fails++;
                    $error("FAIL pulse_kind: valid=%0b err=%0b, expected valid=%0b", frame_valid, frame_err, e.is_valid);
                end
                tests++;
                assert (cyc === e.cyc) else begin
                    fails++;
                    $error("FAIL pulse_latency: cycle %0d, expected %0d", cyc, e.cyc);
                end
                if (e.is_valid) begin
                    tests++;
                    assert (frame_dig === e.dig) else begin
                        fails++;
                        $error("FAIL frame_dig_at_pulse: %0d, expected %0d", frame_dig, e.dig);
                    end
                end
                $display("[TB] cycle %0d: pulse valid=%0b err=%0b dig=%0d", cyc, frame_valid, frame_err, frame_dig);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdio_in = b;
        tick(3);
        sclk_in = 1'b1;
        tick(3);
        sclk_in = 1'b0;
        tick(3);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic push_exp(input bit v, input logic [2:0] d);
        exp_t e;
        e.is_valid = v;
        e.dig      = d;
        e.cyc      = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic latch(input bit v, input logic [2:0] d);
        push_exp(v, d);
        rclk_in = 1'b1;
        tick(3);
        rclk_in = 1'b0;
        tick(4);
    endtask

    task automatic model_set(input logic [2:0] d, input logic [7:0] p, input logic [4:0] c);
        m_pat[d]  = p;
        m_code[d] = c;
        m_dig     = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_pat[i]  = 8'd0;
            m_code[i] = 5'd16;
        end
        m_dig = 3'd0;
    endtask

    task automatic check_state(input string tag);
        logic [63:0] ep;
        logic [39:0] ec;
        logic [7:0]  ed;
        for (int i = 0; i < 8; i++) begin
            ep[8*i +: 8] = m_pat[i];
            ec[5*i +: 5] = m_code[i];
            ed[i]        = m_pat[i][7];
        end
        tests++;
        assert (seg_pat === ep) else begin
            fails++;
            $error("FAIL %s seg_pat: %h, expected %h", tag, seg_pat, ep);
        end
        tests++;
        assert (seg_code === ec) else begin
            fails++;
            $error("FAIL %s seg_code: %h, expected %h", tag, seg_code, ec);
        end
        tests++;
        assert (dot_en === ed) else begin
            fails++;
            $error("FAIL %s dot_en: %h, expected %h", tag, dot_en, ed);
        end
        tests++;
        assert (frame_dig === m_dig) else begin
            fails++;
            $error("FAIL %s frame_dig: %0d, expected %0d", tag, frame_dig, m_dig);
        end
        $display("[TB] %s: seg_pat=%h seg_code=%h dot_en=%h frame_dig=%0d", tag, seg_pat, seg_code, dot_en, frame_dig);
    endtask

    task automatic check_quiet(input string tag);
        tests++;
        assert (frame_valid === 1'b0 && frame_err === 1'b0) else begin
            fails++;
            $error("FAIL %s status: valid=%0b err=%0b, expected 0/0", tag, frame_valid, frame_err);
        end
    endtask

    initial begin
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check_state("reset");
        check_quiet("reset");

        // Digit 0 shows '0' without dot
        send_bits(32'hC0FE, 16);
        latch(1'b1, 3'd0);
        model_set(3'd0, 8'h3F, 5'd0);
        check_state("frame_C0FE");

        // Digit 1: dot only, blank character
        send_bits(32'h7FFD, 16);
        latch(1'b1, 3'd1);
        model_set(3'd1, 8'h80, 5'd16);
        check_state("frame_7FFD");

        // Short frame (15 bits) is rejected
        send_bits(32'h1234, 15);
        latch(1'b0, 3'd0);
        check_state("short_15");

        // Long frame (17 bits) is rejected
        send_bits(32'h1C0FE, 17);
        latch(1'b0, 3'd0);
        check_state("long_17");

        // Following good frame: digit 2 shows 'E'
        send_bits(32'h86FB, 16);
        latch(1'b1, 3'd2);
        model_set(3'd2, 8'h79, 5'd14);
        check_state("frame_86FB");

        // Two digits selected: rejected
        send_bits(32'h92FC, 16);
        latch(1'b0, 3'd0);
        check_state("two_digits");

        // Digit 7 shows '2'
        send_bits(32'hA47F, 16);
        latch(1'b1, 3'd7);
        model_set(3'd7, 8'h5B, 5'd2);
        check_state("frame_A47F");

        // Unrecognised pattern on digit 4 decodes to 31
        send_bits(32'hFEEF, 16);
        latch(1'b1, 3'd4);
        model_set(3'd4, 8'h01, 5'd31);
        check_state("frame_FEEF");

        // No digit selected at all: rejected
        send_bits(32'h00FF, 16);
        latch(1'b0, 3'd0);
        check_state("no_digit");

        // Reset in the middle of a frame discards the partial bits
        send_bits(32'hA5, 8);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        model_reset();
        check_state("mid_reset");
        check_quiet("mid_reset");

        // Latch straight after reset, with no bits shifted: rejected
        latch(1'b0, 3'd0);
        check_state("latch_after_reset");

        // Digit 2 shows '1', every other digit blank
        send_bits(32'hF9FB, 16);
        latch(1'b1, 3'd2);
        model_set(3'd2, 8'h06, 5'd1);
        check_state("frame_F9FB");

        // 16th shift edge and latch edge arrive together: digit 3 shows 'A'
        send_bits(32'h88F7 >> 1, 15);
        sdio_in = 1'b1;
        tick(3);
        push_exp(1'b1, 3'd3);
        sclk_in = 1'b1;
        rclk_in = 1'b1;
        tick(3);
        sclk_in = 1'b0;
        rclk_in = 1'b0;
        tick(4);
        model_set(3'd3, 8'h77, 5'd10);
        check_state("same_cycle_88F7");

        tick(10);
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL pending_events: %0d left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
